// File: rtl/flag_gen_reg.sv
// ============================================================================
// Module   : flag_gen_reg
// Brief    : Registered ALU status-flag generator (C/Z/S/O) with sticky
//            carry/overflow and a saturating overflow-event counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flag_gen_reg #(
    parameter int WIDTH = 128,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [2:0]       opsel,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] result,
    input  logic             cout,
    input  logic             clr,
    output logic             out_valid,
    output logic             c_flag,
    output logic             z_flag,
    output logic             s_flag,
    output logic             o_flag,
    output logic             sticky_c,
    output logic             sticky_o,
    output logic [CNT_W-1:0] ovf_cnt
);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_INC = 3'b010;
    localparam logic [2:0] c_OP_DEC = 3'b011;

    logic             w_as;
    logic             w_bs;
    logic             w_rs;
    logic             w_c;
    logic             w_z;
    logic             w_o;
    logic             w_sticky_c_base;
    logic             w_sticky_o_base;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W-1:0] w_cnt_next;

    logic             r_out_valid;
    logic             r_c_flag;
    logic             r_z_flag;
    logic             r_s_flag;
    logic             r_o_flag;
    logic             r_sticky_c;
    logic             r_sticky_o;
    logic [CNT_W-1:0] r_ovf_cnt;

    assign w_as = a[WIDTH-1];
    assign w_bs = b[WIDTH-1];
    assign w_rs = result[WIDTH-1];
    assign w_z  = (result == '0);

    // SUB/DEC report borrow, which is the inverted adder carry-out.
    always_comb begin
        w_c = 1'b0;
        w_o = 1'b0;
        if (!mode) begin
            case (opsel)
                c_OP_ADD: begin
                    w_c = cout;
                    w_o = (w_as == w_bs) & (w_rs != w_as);
                end
                c_OP_SUB: begin
                    w_c = ~cout;
                    w_o = (w_as != w_bs) & (w_rs != w_as);
                end
                c_OP_INC: begin
                    w_c = cout;
                    w_o = ~w_as & w_rs;
                end
                c_OP_DEC: begin
                    w_c = ~cout;
                    w_o = w_as & ~w_rs;
                end
                default: begin
                    w_c = 1'b0;
                    w_o = 1'b0;
                end
            endcase
        end
    end

    // Clear is applied before accumulation so clr+valid keeps the new event.
    assign w_sticky_c_base = clr ? 1'b0 : r_sticky_c;
    assign w_sticky_o_base = clr ? 1'b0 : r_sticky_o;
    assign w_cnt_base      = clr ? '0 : r_ovf_cnt;

    always_comb begin
        w_cnt_next = w_cnt_base;
        if (in_valid && w_o && !(&w_cnt_base)) begin
            w_cnt_next = w_cnt_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_c_flag    <= 1'b0;
            r_z_flag    <= 1'b0;
            r_s_flag    <= 1'b0;
            r_o_flag    <= 1'b0;
            r_sticky_c  <= 1'b0;
            r_sticky_o  <= 1'b0;
            r_ovf_cnt   <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_c_flag <= w_c;
                r_z_flag <= w_z;
                r_s_flag <= w_rs;
                r_o_flag <= w_o;
            end
            r_sticky_c <= w_sticky_c_base | (in_valid & w_c);
            r_sticky_o <= w_sticky_o_base | (in_valid & w_o);
            r_ovf_cnt  <= w_cnt_next;
        end
    end

    assign out_valid = r_out_valid;
    assign c_flag    = r_c_flag;
    assign z_flag    = r_z_flag;
    assign s_flag    = r_s_flag;
    assign o_flag    = r_o_flag;
    assign sticky_c  = r_sticky_c;
    assign sticky_o  = r_sticky_o;
    assign ovf_cnt   = r_ovf_cnt;

endmodule

`default_nettype wire

// File: tb/tb_flag_gen_reg.sv
// ============================================================================
// Module   : tb_flag_gen_reg
// Brief    : Directed self-checking bench for flag_gen_reg (WIDTH=8, CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flag_gen_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [2:0]       opsel;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             clr;
    logic             out_valid;
    logic             c_flag;
    logic             z_flag;
    logic             s_flag;
    logic             o_flag;
    logic             sticky_c;
    logic             sticky_o;
    logic [CNT_W-1:0] ovf_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    flag_gen_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .opsel     (opsel),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .result    (result),
        .cout      (cout),
        .clr       (clr),
        .out_valid (out_valid),
        .c_flag    (c_flag),
        .z_flag    (z_flag),
        .s_flag    (s_flag),
        .o_flag    (o_flag),
        .sticky_c  (sticky_c),
        .sticky_o  (sticky_o),
        .ovf_cnt   (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag,
                             input logic ev, input logic ec, input logic ez,
                             input logic es, input logic eo, input logic esc,
                             input logic eso, input logic [7:0] ecnt);
        check({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, ev});
        check({tag, ".c_flag"},    {7'd0, c_flag},    {7'd0, ec});
        check({tag, ".z_flag"},    {7'd0, z_flag},    {7'd0, ez});
        check({tag, ".s_flag"},    {7'd0, s_flag},    {7'd0, es});
        check({tag, ".o_flag"},    {7'd0, o_flag},    {7'd0, eo});
        check({tag, ".sticky_c"},  {7'd0, sticky_c},  {7'd0, esc});
        check({tag, ".sticky_o"},  {7'd0, sticky_o},  {7'd0, eso});
        check({tag, ".ovf_cnt"},   {6'd0, ovf_cnt},   ecnt);
    endtask

    // Present one cycle of stimulus, then sample 1 ns after the capturing edge.
    task automatic step(input logic iv, input logic [2:0] op, input logic md,
                        input logic [7:0] ia, input logic [7:0] ib,
                        input logic [7:0] ires, input logic ico, input logic icl);
        in_valid = iv;
        opsel    = op;
        mode     = md;
        a        = ia;
        b        = ib;
        result   = ires;
        cout     = ico;
        clr      = icl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        // Reset held two edges with a valid overflow op presented
        step(1, 3'b000, 0, 8'h7F, 8'h01, 8'h80, 0, 0);
        check_all("rst1", 0, 0, 0, 0, 0, 0, 0, 8'd0);
        step(1, 3'b000, 0, 8'h7F, 8'h01, 8'h80, 0, 0);
        check_all("rst2", 0, 0, 0, 0, 0, 0, 0, 8'd0);
        rst = 1'b0;

        // ADD overflow
        step(1, 3'b000, 0, 8'h7F, 8'h01, 8'h80, 0, 0);
        check_all("add_ovf", 1, 0, 0, 1, 1, 0, 1, 8'd1);
        // ADD carry to zero
        step(1, 3'b000, 0, 8'hFF, 8'h01, 8'h00, 1, 0);
        check_all("add_carry", 1, 1, 1, 0, 0, 1, 1, 8'd1);
        // Idle: flags hold
        step(0, 3'b001, 0, 8'h80, 8'h01, 8'h7F, 0, 0);
        check_all("idle_hold", 0, 1, 1, 0, 0, 1, 1, 8'd1);
        // SUB borrow
        step(1, 3'b001, 0, 8'h00, 8'h01, 8'hFF, 0, 0);
        check_all("sub_borrow", 1, 1, 0, 1, 0, 1, 1, 8'd1);
        // SUB overflow
        step(1, 3'b001, 0, 8'h80, 8'h01, 8'h7F, 1, 0);
        check_all("sub_ovf", 1, 0, 0, 0, 1, 1, 1, 8'd2);
        // Logic mode: no carry/overflow even with an overflowing pattern
        step(1, 3'b000, 1, 8'h7F, 8'h01, 8'h00, 1, 0);
        check_all("logic_mode", 1, 0, 1, 0, 0, 1, 1, 8'd2);
        // opsel 1xx in arithmetic mode
        step(1, 3'b100, 0, 8'h7F, 8'h01, 8'h80, 1, 0);
        check_all("op_1xx", 1, 0, 0, 1, 0, 1, 1, 8'd2);
        // Clear alone: per-op flags untouched
        step(0, 3'b000, 0, 8'h00, 8'h00, 8'h00, 0, 1);
        check_all("clr_alone", 0, 0, 0, 1, 0, 0, 0, 8'd0);

        // INC overflow saturation 1,2,3,3
        step(1, 3'b010, 0, 8'h7F, 8'h00, 8'h80, 0, 0);
        check_all("inc_sat1", 1, 0, 0, 1, 1, 0, 1, 8'd1);
        step(1, 3'b010, 0, 8'h7F, 8'h00, 8'h80, 0, 0);
        check_all("inc_sat2", 1, 0, 0, 1, 1, 0, 1, 8'd2);
        step(1, 3'b010, 0, 8'h7F, 8'h00, 8'h80, 0, 0);
        check_all("inc_sat3", 1, 0, 0, 1, 1, 0, 1, 8'd3);
        step(1, 3'b010, 0, 8'h7F, 8'h00, 8'h80, 0, 0);
        check_all("inc_sat4", 1, 0, 0, 1, 1, 0, 1, 8'd3);

        // Set sticky_c so the clr+DEC step shows it being cleared
        step(1, 3'b000, 0, 8'hFF, 8'h01, 8'h00, 1, 0);
        check_all("add_setc", 1, 1, 1, 0, 0, 1, 1, 8'd3);
        // clr with DEC overflow: clear first, then accumulate
        step(1, 3'b011, 0, 8'h80, 8'h00, 8'h7F, 1, 1);
        check_all("clr_dec_ovf", 1, 0, 0, 0, 1, 0, 1, 8'd1);
        // clr with no valid
        step(0, 3'b011, 0, 8'h80, 8'h00, 8'h7F, 1, 1);
        check_all("clr_novalid", 0, 0, 0, 0, 1, 0, 0, 8'd0);
        // DEC without overflow, no borrow
        step(1, 3'b011, 0, 8'h05, 8'h00, 8'h04, 1, 0);
        check_all("dec_plain", 1, 0, 0, 0, 0, 0, 0, 8'd0);
        // DEC borrow from zero
        step(1, 3'b011, 0, 8'h00, 8'h00, 8'hFF, 0, 0);
        check_all("dec_borrow", 1, 1, 0, 1, 0, 1, 0, 8'd0);

        // Reset mid-stream drops the presented op and overrides clr
        rst = 1'b1;
        step(1, 3'b000, 0, 8'h7F, 8'h01, 8'h80, 0, 1);
        check_all("rst_mid", 0, 0, 0, 0, 0, 0, 0, 8'd0);
        rst = 1'b0;
        step(1, 3'b000, 0, 8'h7F, 8'h01, 8'h80, 0, 0);
        check_all("post_rst", 1, 0, 0, 1, 1, 0, 1, 8'd1);
        step(0, 3'b000, 0, 8'h00, 8'h00, 8'h00, 0, 0);
        check_all("post_idle", 0, 0, 0, 1, 1, 0, 1, 8'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/flag_gen_reg.md
# flag_gen_reg

Parametrised, registered status-flag generator for the ALU datapath. It derives carry, zero, sign and overflow for any operand width from the operation, the operands, the result and the adder carry-out. It registers those flags with a valid strobe, and keeps sticky carry/overflow flags plus a saturating overflow-event counter that software-visible logic can read and clear. It sits after the adder/logic result mux and feeds the ALU status register.

## Interface
Parameters:
- WIDTH, 128, operand/result width in bits (≥ 2)
- CNT_W, 8, width of the overflow-event counter (≥ 1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  operation present this cycle
- opsel  in  3  operation select
- mode  in  1  0 = arithmetic, 1 = logic
- a  in  WIDTH  operand A as presented to the adder
- b  in  WIDTH  operand B as presented to the adder, before inversion
- result  in  WIDTH  operation result
- cout  in  1  adder carry-out of bit WIDTH-1
- clr  in  1  clear sticky flags and counter
- out_valid  out  1  flags below are updated this cycle
- c_flag, z_flag, s_flag, o_flag  out  1 each  registered per-operation flags
- sticky_c, sticky_o  out  1 each  accumulated carry / overflow
- ovf_cnt  out  CNT_W  count of operations with overflow, saturating

## Operation
- msb = bit WIDTH-1. Let as = a[msb], bs = b[msb], rs = result[msb].
- Z = (result == 0). S = rs. These apply in all modes.
- mode=0, opsel 000 ADD: C = cout; O = (as == bs) & (rs != as).
- mode=0, opsel 001 SUB, where the adder computes a + ~b + 1: C = ~cout (borrow); O = (as != bs) & (rs != as).
- mode=0, opsel 010 INC: C = cout; O = ~as & rs.
- mode=0, opsel 011 DEC: C = ~cout; O = as & ~rs.
- mode=0, opsel 1xx, and all opsel values with mode=1: C = 0, O = 0.
- On a cycle with in_valid=1, the next edge loads C/Z/S/O into the flag registers and sets out_valid=1.
- On a cycle with in_valid=0, out_valid is 0 at the next edge and the flag registers hold their value.
- Sticky: sticky_c |= C and sticky_o |= O on each valid operation.
- ovf_cnt increments on each valid operation with O=1. At all-ones it holds (saturates, no wrap).
- clr=1 alone: sticky_c, sticky_o and ovf_cnt go to 0 at the next edge. The per-operation flags are unaffected.
- clr=1 together with in_valid=1: the clear takes effect first, then the new operation is accumulated:
  - sticky_c = C, sticky_o = O
  - ovf_cnt = O ? 1 : 0

## Timing
- Latency: exactly 1 cycle from in_valid to out_valid and to all flag, sticky and counter updates.
- Throughput: one operation per cycle. No back-pressure; in_valid may be asserted every cycle.
- Inputs are sampled only on cycles where in_valid=1. a, b, result, cout, opsel and mode are don't-care otherwise.
- Reset: rst=1 at an edge forces every output to 0. This covers out_valid, all four flags, both sticky flags and ovf_cnt. Reset overrides in_valid and clr on the same edge.
- Reset during a stream: the operation presented on the reset edge is dropped. The first edge after rst falls with in_valid=1 produces normal output.
- All outputs are driven directly from registers. There is no combinational path from inputs to outputs.

## Test plan
- Reset values: with WIDTH=8, hold rst for 2 cycles while in_valid=1 and clr=0 → all outputs 0. On the first valid op after release, out_valid=1 one cycle later.
- ADD overflow and carry, WIDTH=8:
  - a=0x7F, b=0x01, result=0x80, cout=0 → C=0, Z=0, S=1, O=1; ovf_cnt=1.
  - a=0xFF, b=0x01, result=0x00, cout=1 → C=1, Z=1, S=0, O=0.
- SUB borrow, WIDTH=8: a=0x00, b=0x01, result=0xFF, cout=0 → C=1, S=1, O=0. Then a=0x80, b=0x01, result=0x7F, cout=1 → C=0, O=1.
- Logic mode: mode=1, result=0x00 with cout=1 → C=0, O=0, Z=1. Sticky flags are unchanged.
- Saturation, CNT_W=2: four consecutive INC ops with a=0x7F, result=0x80 → ovf_cnt sequence 1, 2, 3, 3.
- Simultaneous clr and overflow, starting from sticky_o=1 and ovf_cnt=3: clr=1 with a DEC of a=0x80, result=0x7F → sticky_o=1, ovf_cnt=1. clr=1 with no valid → sticky_c, sticky_o and ovf_cnt all 0, and o_flag unchanged.
